// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-predictor widths, queue entry layout and pipeline flush reasons.
package bp_pkg;
  localparam int BP_FEAT = 8;
  localparam int BP_CONF_W = 11;
  typedef struct packed {
    logic [BP_FEAT-1:0] features;
    logic pred;
    logic signed [BP_CONF_W-1:0] conf;
  } bp_entry_t;
  typedef enum logic [1:0] {
    FLUSH_NONE,
    FLUSH_MISPREDICT,
    FLUSH_EXCEPTION,
    FLUSH_TRAP
  } bp_flush_reason_e;
endpackage

// File: rtl/bp_sync_fifo.sv
// bp_sync_fifo: synchronous circular FIFO with push, pop and clear_all; clear_all drops every entry.
module bp_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 20,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          clear_all,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full && !clear_all;
  assign do_pop = pop && !empty;
  assign pop_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clear_all) begin
      rd_ptr <= wr_ptr;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/bp_train_queue.sv
// bp_train_queue: in-order branch tracking queue feeding perceptron training; BP_TRAIN_STATS_EN builds br_cnt/miss_cnt.
module bp_train_queue
  import bp_pkg::*;
#(
  parameter int FEAT = BP_FEAT,
  parameter int DEPTH = 8,
  parameter int CONF_W = BP_CONF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [FEAT-1:0]   push_features,
  input  logic              push_pred,
  input  logic [CONF_W-1:0] push_conf,
  output logic              push_ready,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  input  logic              flush,
  output logic              train_en,
  output logic [FEAT-1:0]   train_features,
  output logic              actual_taken,
  output logic              mispredict,
  output logic [CONF_W-1:0] head_conf,
  output logic              underflow,
  output logic [31:0]       br_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int W = FEAT + 1 + CONF_W;
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] head;
  logic [AW:0] count;
  logic full, empty, res_ok, mis, push_ok;
  assign push_ready = !full;
  assign res_ok = resolve_valid && count != '0;
  assign mis = res_ok && (head[CONF_W] ^ resolve_taken);
  // a mispredicting resolve makes any same-cycle push wrong-path
  assign push_ok = push_valid && push_ready && !flush && !mis;
  bp_sync_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push_ok),
    .push_data({push_features, push_pred, push_conf}),
    .pop(res_ok),
    .clear_all(flush || mis),
    .pop_data(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      train_en <= 1'b0;
      train_features <= '0;
      actual_taken <= 1'b0;
      mispredict <= 1'b0;
      head_conf <= '0;
      underflow <= 1'b0;
    end else begin
      train_en <= res_ok;
      mispredict <= mis;
      underflow <= underflow || (resolve_valid && empty);
      if (res_ok) begin
        train_features <= head[W-1 -: FEAT];
        actual_taken <= resolve_taken;
        head_conf <= head[CONF_W-1:0];
      end
    end
  end
`ifdef BP_TRAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      br_cnt <= br_cnt + 32'(res_ok);
      miss_cnt <= miss_cnt + 32'(mis);
    end
  end
`else
  assign br_cnt = '0;
  assign miss_cnt = '0;
`endif
endmodule
